// File: rtl/gfau_ctrl_pkg.sv
// Shared definitions for the GFAU controller: op encodings, response error codes,
// FSM state type and the queued command layout.
package gfau_ctrl_pkg;

  localparam logic [1:0] GF_ADD  = 2'b00;
  localparam logic [1:0] GF_SUB  = 2'b01;
  localparam logic [1:0] GF_MULT = 2'b10;
  localparam logic [1:0] GF_DIV  = 2'b11;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_FLAG    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam int unsigned CmdW = 98;

  typedef enum logic [1:0] {StIdle, StIssue, StRelease, StResp} state_e;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] prime;
  } cmd_t;

  // One-hot done flag expected for an op, ordered {div, mult, sub, add}.
  function automatic logic [3:0] op_flag(input logic [1:0] op);
    return 4'b0001 << op;
  endfunction

endpackage

// File: rtl/gfau_cmd_fifo.sv
// Command buffer: power-of-two depth, extra pointer MSB distinguishes full from empty.
module gfau_cmd_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 98
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned PtrW  = AddrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic             do_push, do_pop;

  assign full_o  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                   (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q[AddrW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + PtrW'(1);
    if (do_pop)  rptr_d = rptr_q + PtrW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AddrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/gfau_ctrl.sv
// GFAU controller: queues commands, drives one four-phase request at a time to the GFAU
// and returns each result, flag-mismatch or timeout as a response.
module gfau_ctrl
  import gfau_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4095
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic [31:0] cmd_prime,
  output logic [31:0] in_0,
  output logic [31:0] in_1,
  output logic [31:0] prime,
  output logic [1:0]  operation_select,
  output logic        done_from_control,
  input  logic        done_to_control,
  input  logic [31:0] result,
  input  logic        done_add,
  input  logic        done_sub,
  input  logic        done_mult,
  input  logic        done_div,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_op,
  output logic [1:0]  rsp_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [31:0]     in_0_q, in_0_d, in_1_q, in_1_d, prime_q, prime_d;
  logic [1:0]      op_q, op_d;
  logic [31:0]     rsp_data_q, rsp_data_d;
  logic [1:0]      rsp_op_q, rsp_op_d, rsp_err_q, rsp_err_d;
  logic            rtz_wait_q, rtz_wait_d;
  logic            fifo_full, fifo_empty, fifo_pop;
  logic [CmdW-1:0] fifo_rdata;
  cmd_t            head;
  logic [3:0]      done_flags;
  logic            tmo_hit;

  assign head       = fifo_rdata;
  assign done_flags = {done_div, done_mult, done_sub, done_add};
  assign cnt_inc    = cnt_q + CntW'(1);
  assign tmo_hit    = (cnt_inc == CntW'(TIMEOUT_CYCLES));

  gfau_cmd_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (CmdW)
  ) u_cmd_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_rst),
    .push_i  (cmd_valid),
    .wdata_i ({cmd_op, cmd_a, cmd_b, cmd_prime}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      in_0_q     <= '0;
      in_1_q     <= '0;
      prime_q    <= '0;
      op_q       <= GF_ADD;
      rsp_data_q <= '0;
      rsp_op_q   <= GF_ADD;
      rsp_err_q  <= ERR_OK;
      rtz_wait_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      in_0_q     <= in_0_d;
      in_1_q     <= in_1_d;
      prime_q    <= prime_d;
      op_q       <= op_d;
      rsp_data_q <= rsp_data_d;
      rsp_op_q   <= rsp_op_d;
      rsp_err_q  <= rsp_err_d;
      rtz_wait_q <= rtz_wait_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    in_0_d     = in_0_q;
    in_1_d     = in_1_q;
    prime_d    = prime_q;
    op_d       = op_q;
    rsp_data_d = rsp_data_q;
    rsp_op_d   = rsp_op_q;
    rsp_err_d  = rsp_err_q;
    rtz_wait_d = rtz_wait_q;
    fifo_pop   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A timed-out GFAU may still hold its done level; let it return to zero first.
        if (rtz_wait_q) begin
          if (!done_to_control) rtz_wait_d = 1'b0;
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          op_d     = head.op;
          in_0_d   = head.a;
          in_1_d   = head.b;
          prime_d  = head.prime;
          cnt_d    = '0;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        cnt_d = cnt_inc;
        if (done_to_control) begin
          rsp_data_d = result;
          rsp_op_d   = op_q;
          rsp_err_d  = (done_flags == op_flag(op_q)) ? ERR_OK : ERR_FLAG;
          state_d    = StRelease;
        end else if (tmo_hit) begin
          rsp_data_d = '0;
          rsp_op_d   = op_q;
          rsp_err_d  = ERR_TIMEOUT;
          rtz_wait_d = 1'b1;
          state_d    = StResp;
        end
      end
      StRelease: begin
        cnt_d = cnt_inc;
        if (!done_to_control) begin
          state_d = StResp;
        end else if (tmo_hit) begin
          rsp_data_d = '0;
          rsp_err_d  = ERR_TIMEOUT;
          rtz_wait_d = 1'b1;
          state_d    = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cmd_ready         = !fifo_full;
    done_from_control = (state_q == StIssue);
    rsp_valid         = (state_q == StResp);
    in_0              = in_0_q;
    in_1              = in_1_q;
    prime             = prime_q;
    operation_select  = op_q;
    rsp_data          = rsp_data_q;
    rsp_op            = rsp_op_q;
    rsp_err           = rsp_err_q;
  end

endmodule

// File: tb/tb_gfau_ctrl.sv
// Self-checking bench for gfau_ctrl: a behavioural GF(p) arithmetic unit answers requests and
// a queue of expected responses, computed from the pushed commands, is checked in order.
module tb_gfau_ctrl;

  localparam int MNormal   = 0;
  localparam int MMismatch = 1;
  localparam int MNever    = 2;

  logic        i_clk, i_rst;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_a, cmd_b, cmd_prime;
  logic [31:0] in_0, in_1, prime;
  logic [1:0]  operation_select;
  logic        done_from_control, done_to_control;
  logic [31:0] result;
  logic [3:0]  gf_flags;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_op, rsp_err;

  int tests = 0;
  int fails = 0;
  int gf_mode = MNormal;
  int gf_delay = 0;
  bit gf_stall = 1'b0;
  int gf_wait = 0;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  op;
    logic [1:0]  err;
  } exp_t;
  exp_t exp_q[$];
  int primes[5] = '{7, 11, 13, 31, 251};

  gfau_ctrl #(
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_op            (cmd_op),
    .cmd_a             (cmd_a),
    .cmd_b             (cmd_b),
    .cmd_prime         (cmd_prime),
    .in_0              (in_0),
    .in_1              (in_1),
    .prime             (prime),
    .operation_select  (operation_select),
    .done_from_control (done_from_control),
    .done_to_control   (done_to_control),
    .result            (result),
    .done_add          (gf_flags[0]),
    .done_sub          (gf_flags[1]),
    .done_mult         (gf_flags[2]),
    .done_div          (gf_flags[3]),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_data          (rsp_data),
    .rsp_op            (rsp_op),
    .rsp_err           (rsp_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] gf_calc(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] p);
    longint aa = a, bb = b, pp = p, inv = 0;
    case (op)
      2'd0: return 32'((aa + bb) % pp);
      2'd1: return 32'((aa - bb + pp) % pp);
      2'd2: return 32'((aa * bb) % pp);
      default: begin
        for (longint x = 1; x < pp; x++) if ((bb * x) % pp == 1) inv = x;
        return 32'((aa * inv) % pp);
      end
    endcase
  endfunction

  function automatic exp_t model_rsp(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b, input logic [31:0] p, input int mode);
    exp_t e;
    e.op = op;
    if (mode == MNever) begin
      e.d   = '0;
      e.err = 2'b10;
    end else begin
      e.d   = gf_calc(op, a, b, p);
      e.err = (mode == MMismatch) ? 2'b01 : 2'b00;
    end
    return e;
  endfunction

  // GFAU model: answers a held request after gf_delay cycles, returns to zero after release.
  always @(negedge i_clk) begin
    if (done_to_control) begin
      if (!done_from_control) begin
        done_to_control <= 1'b0;
        gf_flags        <= 4'b0;
      end
    end else if (done_from_control && gf_mode != MNever && !gf_stall) begin
      if (gf_wait >= gf_delay) begin
        done_to_control <= 1'b1;
        result          <= gf_calc(operation_select, in_0, in_1, prime);
        gf_flags        <= (gf_mode == MMismatch) ? (4'b0001 << (operation_select + 2'd3))
                                                  : (4'b0001 << operation_select);
        gf_wait         <= 0;
      end else begin
        gf_wait <= gf_wait + 1;
      end
    end else begin
      gf_wait <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] p, input bit track);
    int n = 0;
    @(negedge i_clk);
    while (!cmd_ready && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    if (!cmd_ready) check("push_ready", {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_prime = p;
    @(posedge i_clk);
    #1 cmd_valid = 1'b0;
    if (track) exp_q.push_back(model_rsp(op, a, b, p, gf_mode));
  endtask

  task automatic push_rand(input bit track);
    logic [1:0]  op;
    logic [31:0] p, a, b;
    op = 2'($urandom_range(0, 3));
    p  = primes[$urandom_range(0, 4)];
    a  = $urandom_range(0, p - 1);
    b  = (op == 2'd3) ? $urandom_range(1, p - 1) : $urandom_range(0, p - 1);
    push(op, a, b, p, track);
  endtask

  // Waits for a response, holds rsp_ready low for 'hold' cycles checking stability, then accepts.
  task automatic get_rsp(input string tag, input int hold);
    int   n = 0;
    exp_t e;
    @(negedge i_clk);
    while (!rsp_valid && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    check({tag, "_valid"}, {31'b0, rsp_valid}, 32'd1);
    if (rsp_valid) begin
      check({tag, "_dfc_low"}, {31'b0, done_from_control}, 32'd0);
      if (exp_q.size() == 0) begin
        check({tag, "_unexpected"}, exp_q.size(), 32'd1);
      end else begin
        e = exp_q.pop_front();
        for (int i = 0; i < hold; i++) begin
          check({tag, "_hold_data"}, rsp_data, e.d);
          check({tag, "_hold_dfc"}, {31'b0, done_from_control}, 32'd0);
          @(negedge i_clk);
        end
        check({tag, "_data"}, rsp_data, e.d);
        check({tag, "_op"}, {30'b0, rsp_op}, {30'b0, e.op});
        check({tag, "_err"}, {30'b0, rsp_err}, {30'b0, e.err});
      end
      rsp_ready = 1'b1;
      @(posedge i_clk);
      #1 rsp_ready = 1'b0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, hi, bad;
    i_rst = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_a = '0;
    cmd_b = '0;
    cmd_prime = '0;
    rsp_ready = 1'b0;
    done_to_control = 1'b0;
    result = '0;
    gf_flags = '0;

    // Reset state
    repeat (3) @(negedge i_clk);
    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("rst_dfc", {31'b0, done_from_control}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_in_0", in_0, 32'd0);
    check("rst_in_1", in_1, 32'd0);
    check("rst_prime", prime, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_opsel", {30'b0, operation_select}, 32'd0);
    check("rst_rsp_err", {30'b0, rsp_err}, 32'd0);
    i_rst = 1'b1;

    // Directed add: (5 + 9) mod 11 = 3
    gf_delay = 2;
    push(2'd0, 32'd5, 32'd9, 32'd11, 1'b1);
    get_rsp("add", 0);

    // Random batches in normal mode
    for (int bt = 0; bt < 4; bt++) begin
      gf_delay = $urandom_range(0, 4);
      for (int k = 0; k < 3; k++) push_rand(1'b1);
      for (int k = 0; k < 3; k++) get_rsp("rand", $urandom_range(0, 3));
    end

    // Five back-to-back pushes with the GFAU stalled
    gf_delay = 1;
    gf_stall = 1'b1;
    for (int k = 0; k < 5; k++) push_rand(1'b1);
    check("full_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    gf_stall = 1'b0;
    for (int k = 0; k < 5; k++) get_rsp("order", 0);

    // Op-flag mismatch
    gf_mode = MMismatch;
    push(2'd3, 32'd6, 32'd4, 32'd13, 1'b1);
    get_rsp("mismatch_div", 0);
    push_rand(1'b1);
    get_rsp("mismatch_rand", 0);

    // Timeout: GFAU never answers
    gf_mode = MNever;
    push_rand(1'b1);
    n = 0;
    hi = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge i_clk);
      if (done_from_control) hi++;
      n++;
    end
    check("tmo_dfc_cycles", hi, 32'd16);
    get_rsp("timeout", 0);
    gf_mode = MNormal;
    push_rand(1'b1);
    get_rsp("after_tmo", 0);

    // Response back-pressure with a second command queued
    gf_delay = 1;
    push_rand(1'b1);
    push_rand(1'b1);
    get_rsp("hold", 10);
    get_rsp("hold_next", 0);

    // Reset while in ISSUE with a command still queued
    gf_stall = 1'b1;
    push_rand(1'b0);
    push_rand(1'b0);
    n = 0;
    while (!done_from_control && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    check("mid_rst_issue", {31'b0, done_from_control}, 32'd1);
    @(negedge i_clk);
    #1 i_rst = 1'b0;
    #1;
    check("mid_rst_dfc", {31'b0, done_from_control}, 32'd0);
    check("mid_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("mid_rst_in_0", in_0, 32'd0);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b1;
    gf_stall = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge i_clk);
      if (rsp_valid || done_from_control) bad++;
    end
    check("post_rst_idle", bad, 32'd0);
    check("post_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("exp_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
